// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// state encodings and the counter-width helper.
package seq_mult_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Smallest r with 2**r >= value; gives 1 for value=2 so the counter is never zero-width.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sign_conv.sv
// Conditional two's-complement negation: out = en ? -in : in, at width N.
module sign_conv #(
   parameter int unsigned N = 8
) (
   input  logic         en,
   input  logic [N-1:0] in,
   output logic [N-1:0] out
);

   assign out = en ? (~in + N'(1)) : in;

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential shift-and-add multiplier, one multiplier bit per clock, with
// start/done handshake, signed/unsigned mode and optional early termination.
module seq_mult_ctrl
   import seq_mult_pkg::*;
#(
   parameter int unsigned W          = 8,
   parameter int unsigned EARLY_EXIT = 0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           signed_mode,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           ready,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] product
);

   localparam int unsigned CW = clog2(W);

   logic [1:0]     state_q, state_d;
   logic [2*W-1:0] mcand_q, mcand_d;
   logic [2*W-1:0] acc_q, acc_d;
   logic [2*W-1:0] product_q, product_d;
   logic [W-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           neg_q, neg_d;

   logic [W-1:0]   mag_a, mag_b, mplier_shift;
   logic [2*W-1:0] acc_next, prod_fix;
   logic           last_iter;

   sign_conv #(.N(W)) u_mag_a (
      .en  (signed_mode & a[W-1]),
      .in  (a),
      .out (mag_a)
   );

   sign_conv #(.N(W)) u_mag_b (
      .en  (signed_mode & b[W-1]),
      .in  (b),
      .out (mag_b)
   );

   sign_conv #(.N(2*W)) u_fix (
      .en  (neg_q),
      .in  (acc_next),
      .out (prod_fix)
   );

   // Magnitudes are at most 2^(W-1) and 2^W-1, so the 2W-bit sum cannot overflow.
   always_comb begin
      acc_next     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
      mplier_shift = mplier_q >> 1;
      last_iter    = (cnt_q == CW'(W - 1)) || ((EARLY_EXIT != 0) && (mplier_shift == '0));
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_RUN;
         ST_RUN:  if (last_iter) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ready = (state_q == ST_IDLE);
      busy  = (state_q == ST_RUN);
      done  = (state_q == ST_DONE);
   end

   always_comb begin
      mcand_d   = mcand_q;
      acc_d     = acc_q;
      mplier_d  = mplier_q;
      cnt_d     = cnt_q;
      neg_d     = neg_q;
      product_d = product_q;
      if (state_q == ST_IDLE && start) begin
         mcand_d  = {{W{1'b0}}, mag_a};
         mplier_d = mag_b;
         acc_d    = '0;
         cnt_d    = '0;
         neg_d    = signed_mode & (a[W-1] ^ b[W-1]);
      end else if (state_q == ST_RUN) begin
         acc_d    = acc_next;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_shift;
         cnt_d    = cnt_q + CW'(1);
         if (last_iter) product_d = prod_fix;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_q   <= '0;
         acc_q     <= '0;
         mplier_q  <= '0;
         cnt_q     <= '0;
         neg_q     <= 1'b0;
         product_q <= '0;
      end else begin
         mcand_q   <= mcand_d;
         acc_q     <= acc_d;
         mplier_q  <= mplier_d;
         cnt_q     <= cnt_d;
         neg_q     <= neg_d;
         product_q <= product_d;
      end
   end

   assign product = product_q;

endmodule

// File: doc/seq_mult_ctrl.md
# seq_mult_ctrl

Parametrised sequential shift-and-add multiplier with start/done handshake, synchronous reset, signed/unsigned mode and optional early termination. It accepts two W-bit operands, iterates one multiplier bit per clock and returns a full 2W-bit product held stable until the next operation. It is the general-purpose arithmetic engine for datapaths that cannot afford a combinational multiplier.

## Interface
- `W`, 8: operand width, minimum 2.
- `EARLY_EXIT`, 0: when 1, the run ends as soon as the remaining multiplier bits are all zero.
- `clk` input 1: clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request; sampled only while `ready`=1.
- `signed_mode` input 1: 1 treats `a`/`b` as two's complement; sampled with `start`.
- `a` input W: multiplicand, sampled with `start`.
- `b` input W: multiplier, sampled with `start`.
- `ready` output 1: state IDLE.
- `busy` output 1: state RUN.
- `done` output 1: one-cycle pulse, product valid.
- `product` output 2W: result register.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `start`=1 loads `mcand` (2W, zero-extended |a|), `mplier` (W, |b|), `acc`=0, `cnt`=0 and `neg` = signed_mode & (a[W-1] ^ b[W-1]); go to RUN.
  - In unsigned mode |x| = x. In signed mode |x| is the conditional two's complement in W bits; the most-negative value maps to 2^(W-1) unsigned, which is exact.
- RUN, one iteration per cycle:
  - If `mplier[0]`, `acc` <= `acc` + `mcand`, in 2W bits with no carry-out possible.
  - `mcand` <= `mcand` << 1.
  - `mplier` <= `mplier` >> 1, zero-fill.
  - `cnt`++.
  - Exit to DONE after the iteration where `cnt`==W-1, or, if EARLY_EXIT=1, where the shifted `mplier` is 0.
- On the RUN->DONE edge, `product` <= `neg` ? -(acc_next) : acc_next, in 2W bits. `acc_next` is the accumulator value including that iteration's add.
- DONE: `done`=1 for exactly one cycle, then unconditionally to IDLE. `start` is ignored in DONE.
- `start` is ignored in RUN and DONE. The operation in flight is unaffected.
- `product` changes only on the RUN->DONE edge and on reset. It holds otherwise, including across later IDLE cycles.
- b=0: with EARLY_EXIT=1 the run ends after 1 iteration; with EARLY_EXIT=0 it runs W iterations. The product is 0 either way.

## Timing
- Reset (`rst`=1 at a clock edge), which applies in any state including mid-RUN: state=IDLE, `product`=0, `acc`=0, `cnt`=0, `ready`=1, `busy`=0, `done`=0. The aborted operation produces no `done`.
- `ready`, `busy` and `done` are decoded from registered state only, with no combinational path from inputs.
- `start` sampled at edge t: `busy`=1 from t+1. With EARLY_EXIT=0, the last RUN cycle is t+W and `done`=1 with the valid `product` at t+W+1. `ready`=1 again at t+W+2.
- With EARLY_EXIT=1: k = max(1, index of highest set bit of |b| + 1) iterations. `done` at t+k+1.
- Back-to-back throughput: one operation per W+2 cycles, because the earliest next `start` is sampled at t+W+2.
- `start` held high continuously: a new operation begins on every IDLE cycle, using the operand values present at that edge.

## Structure
- Shared package `seq_mult_pkg` holds:
  - state encoding localparams `ST_IDLE`=2'd0, `ST_RUN`=2'd1, `ST_DONE`=2'd2;
  - the counter-width function clog2(W).
- One sub-module is natural: `sign_conv` (parameter N), which computes out = en ? -in : in. It is instantiated twice at width W for operand magnitudes and once at width 2W for the result sign fix.
- The counter is clog2(W) bits wide. State decoding and the datapath live in the top.

## Test plan
- Unsigned, W=8, EARLY_EXIT=0: a=13, b=11 -> `product`=0x008F; `done` exactly 9 cycles after the start edge; `busy` high for 8 cycles.
- Unsigned extremes: a=255, b=255 -> 0xFE01. Signed: a=-3 (0xFD), b=5 -> 0xFFF1. Signed a=-128, b=-128 -> 0x4000. Signed a=-128, b=1 -> 0xFF80.
- EARLY_EXIT=1: a=7, b=3 -> 0x0015 with `done` at t+3. Also b=0 -> 0 with `done` at t+2.
- `start` asserted with new operands during RUN and during DONE -> ignored. `product` equals the first operation's result and the next accepted `start` gives its own correct result.
- `rst` pulsed mid-RUN (after 4 iterations) -> next cycle IDLE, `product`=0, no `done` pulse. A subsequent 6x7 gives 0x002A.
- Randomised 1000 operations per mode at W=8 and W=5 against a reference model, checking `product` and `done` latency.
